// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the branch history table.
//   idx_w     - table index width for a given entry count
//   ctr_next  - one saturating counter step (up or down) for a given width
//   pc_index  - table index taken from a PC, word-aligned (bits [1:0] dropped)
package bp_pkg;
    localparam int MAX_CTR_W = 4;
    localparam int MAX_IDX_W = 10;
    localparam int MAX_PC_W  = 64;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic logic [MAX_CTR_W-1:0] ctr_next(input logic [MAX_CTR_W-1:0] ctr,
                                                      input logic up, input int w);
        logic [MAX_CTR_W-1:0] top;
        top = MAX_CTR_W'((1 << w) - 1);
        return up ? ((ctr == top) ? ctr : ctr + 4'd1) : ((ctr == 4'd0) ? ctr : ctr - 4'd1);
    endfunction

    function automatic logic [MAX_IDX_W-1:0] pc_index(input logic [MAX_PC_W-1:0] pc, input int iw);
        return MAX_IDX_W'((pc >> 2) & ((64'd1 << iw) - 64'd1));
    endfunction
endpackage

// File: rtl/bht_predictor_if.sv
// bht_predictor_if: lookup/update bundle between the pipeline and the branch history table.
//   master (pipeline): drives lookup_pc_i, update_valid_i, update_pc_i, update_taken_i, update_pred_i
//   slave (predictor): drives predict_o, mispredict_o, mispred_cnt_o
interface bht_predictor_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic [PC_W-1:0]  lookup_pc_i;
    logic             predict_o;
    logic             update_valid_i;
    logic [PC_W-1:0]  update_pc_i;
    logic             update_taken_i;
    logic             update_pred_i;
    logic             mispredict_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output lookup_pc_i, update_valid_i, update_pc_i, update_taken_i, update_pred_i,
        input  predict_o, mispredict_o, mispred_cnt_o
    );

    modport slave (
        input  lookup_pc_i, update_valid_i, update_pc_i, update_taken_i, update_pred_i,
        output predict_o, mispredict_o, mispred_cnt_o
    );
endinterface

// File: rtl/bht_sat_ctr.sv
// bht_sat_ctr: one W-bit saturating up/down counter with synchronous reset value INIT.
//   clk_i, rst_i : clock, sync active-high reset (loads INIT, beats en)
//   en, up       : step enable and direction (1 = increment)
//   q            : counter value
module bht_sat_ctr
    import bp_pkg::*;
#(
    parameter int W    = 2,
    parameter int INIT = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] q
);
    logic [MAX_CTR_W-1:0] nxt;

    assign nxt = ctr_next(MAX_CTR_W'(q), up, W);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            q <= W'(INIT);
        else if (en)
            q <= nxt[W-1:0];
    end
endmodule

// File: rtl/bht_predictor.sv
// bht_predictor: branch history table of ENTRIES saturating counters with misprediction counting.
//   clk_i, rst_i : clock, sync active-high reset
//   bus (slave)  : combinational lookup (lookup_pc_i -> predict_o), EX training
//                  (update_*), combinational mispredict_o flush request, mispred_cnt_o
//   Optional: define BHT_GSHARE_EN to XOR a global history register into both indices.
module bht_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 16,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 2**CTR_W - 1,
    parameter int PC_W     = 32,
    parameter int CNT_W    = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    bht_predictor_if.slave      bus
);
    localparam int IDX_W = idx_w(ENTRIES);

    logic [MAX_PC_W-1:0]  lpc, upc;
    logic [MAX_IDX_W-1:0] lraw, uraw;
    logic [IDX_W-1:0]     lidx, uidx;
    logic [CTR_W-1:0]     ctr [ENTRIES];
    logic [CNT_W-1:0]     cnt;

    assign lpc  = MAX_PC_W'(bus.lookup_pc_i);
    assign upc  = MAX_PC_W'(bus.update_pc_i);
    assign lraw = pc_index(lpc, IDX_W);
    assign uraw = pc_index(upc, IDX_W);

`ifdef BHT_GSHARE_EN
    logic [IDX_W-1:0] ghr;

    // Both lookup and update hash with the pre-shift history.
    assign lidx = lraw[IDX_W-1:0] ^ ghr;
    assign uidx = uraw[IDX_W-1:0] ^ ghr;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            ghr <= '0;
        else if (bus.update_valid_i)
            ghr <= IDX_W'({ghr, bus.update_taken_i});
    end
`else
    assign lidx = lraw[IDX_W-1:0];
    assign uidx = uraw[IDX_W-1:0];
`endif

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        bht_sat_ctr #(.W(CTR_W), .INIT(INIT_CTR)) u_ctr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en    (bus.update_valid_i && (uidx == IDX_W'(g))),
            .up    (bus.update_taken_i),
            .q     (ctr[g])
        );
    end

    // No bypass: a same-cycle update to the looked-up entry is seen next cycle.
    assign bus.predict_o     = ctr[lidx][CTR_W-1];
    assign bus.mispredict_o  = bus.update_valid_i & (bus.update_taken_i != bus.update_pred_i);
    assign bus.mispred_cnt_o = cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= '0;
        else if (bus.mispredict_o && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end
endmodule
